// File: rtl/br_recovery_ctrl.sv
// Commit-time branch misprediction recovery sequencer: tracks the oldest
// mispredicted branch, flushes/redirects when it commits, then drains the frontend.
module br_recovery_ctrl #(
  parameter int ROB_IDX_W    = 5,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 br_valid,
  input  logic [ROB_IDX_W-1:0] br_rob_id,
  input  logic                 br_miss_predict,
  input  logic [31:0]          br_target_address,
  input  logic [ROB_IDX_W-1:0] rob_head_id,
  input  logic                 rob_commit_valid,
  output logic                 mispredict_pending,
  output logic                 flush,
  output logic                 redirect_valid,
  output logic [31:0]          redirect_pc,
  output logic                 frontend_stall
);

  typedef enum logic [1:0] {IDLE, WAIT_COMMIT, FLUSH, DRAIN} state_t;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES);

  state_t                 state_q, state_d;
  logic [ROB_IDX_W-1:0]   pend_id_q, pend_id_d;
  logic [31:0]            pend_target_q, pend_target_d;
  logic [3:0]             drain_cnt_q, drain_cnt_d;

  logic                   mispredict;
  logic [ROB_IDX_W-1:0]   age_br;
  logic [ROB_IDX_W-1:0]   age_pend;

  // Modular subtraction at ROB_IDX_W bits gives the wrap-correct age directly.
  assign mispredict = br_valid && br_miss_predict;
  assign age_br     = br_rob_id - rob_head_id;
  assign age_pend   = pend_id_q - rob_head_id;

  always_comb begin
    state_d       = state_q;
    pend_id_d     = pend_id_q;
    pend_target_d = pend_target_q;
    drain_cnt_d   = drain_cnt_q;
    case (state_q)
      IDLE: begin
        if (mispredict) begin
          pend_id_d     = br_rob_id;
          pend_target_d = br_target_address;
          state_d       = WAIT_COMMIT;
        end
      end
      WAIT_COMMIT: begin
        // Commit wins: any same-cycle broadcast is younger and about to be squashed.
        if (rob_commit_valid && (rob_head_id == pend_id_q)) begin
          state_d = FLUSH;
        end else if (mispredict && (age_br < age_pend)) begin
          pend_id_d     = br_rob_id;
          pend_target_d = br_target_address;
        end
      end
      FLUSH: begin
        drain_cnt_d = DRAIN_LOAD;
        state_d     = DRAIN;
      end
      DRAIN: begin
        drain_cnt_d = drain_cnt_q - 4'd1;
        if (drain_cnt_q == 4'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      pend_id_q     <= '0;
      pend_target_q <= '0;
      drain_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      pend_id_q     <= pend_id_d;
      pend_target_q <= pend_target_d;
      drain_cnt_q   <= drain_cnt_d;
    end
  end

  assign mispredict_pending = (state_q == WAIT_COMMIT);
  assign flush              = (state_q == FLUSH);
  assign redirect_valid     = (state_q == FLUSH);
  assign redirect_pc        = (state_q == FLUSH) ? pend_target_q : 32'h0;
  assign frontend_stall     = (state_q == FLUSH) || (state_q == DRAIN);

endmodule

// File: tb/tb_br_recovery_ctrl.sv
// Self-checking bench for br_recovery_ctrl: directed recovery scenarios plus
// randomized traffic compared against a cycle-level behavioural model.
module tb_br_recovery_ctrl;

  localparam int W     = 5;
  localparam int DRAIN = 2;
  localparam int DEPTH = 1 << W;

  logic          clk = 1'b0;
  logic          rst;
  logic          br_valid;
  logic [W-1:0]  br_rob_id;
  logic          br_miss_predict;
  logic [31:0]   br_target_address;
  logic [W-1:0]  rob_head_id;
  logic          rob_commit_valid;
  logic          mispredict_pending;
  logic          flush;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          frontend_stall;

  int total = 0;
  int bad   = 0;

  // Model: a pending flag with id/target, and a count of recovery cycles left
  // (DRAIN+1 means the flush cycle; anything >0 is stalled).
  bit        m_pend;
  int        m_id;
  logic [31:0] m_tgt;
  int        m_rec;

  br_recovery_ctrl #(.ROB_IDX_W(W), .DRAIN_CYCLES(DRAIN)) dut (
    .clk               (clk),
    .rst               (rst),
    .br_valid          (br_valid),
    .br_rob_id         (br_rob_id),
    .br_miss_predict   (br_miss_predict),
    .br_target_address (br_target_address),
    .rob_head_id       (rob_head_id),
    .rob_commit_valid  (rob_commit_valid),
    .mispredict_pending(mispredict_pending),
    .flush             (flush),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .frontend_stall    (frontend_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int age(input int x, input int head);
    return ((x - head) % DEPTH + DEPTH) % DEPTH;
  endfunction

  task automatic model_edge();
    bit miss;
    miss = br_valid && br_miss_predict;
    if (!rst) begin
      m_pend = 0; m_id = 0; m_tgt = 0; m_rec = 0;
    end else if (m_rec > 0) begin
      m_rec--;
    end else if (m_pend) begin
      if (rob_commit_valid && int'(rob_head_id) == m_id) begin
        m_pend = 0;
        m_rec  = DRAIN + 1;
      end else if (miss && age(int'(br_rob_id), int'(rob_head_id)) < age(m_id, int'(rob_head_id))) begin
        m_id  = int'(br_rob_id);
        m_tgt = br_target_address;
      end
    end else if (miss) begin
      m_pend = 1;
      m_id   = int'(br_rob_id);
      m_tgt  = br_target_address;
    end
  endtask

  task automatic check_all();
    logic fl;
    fl = (m_rec == DRAIN + 1);
    chk("pending", {31'b0, mispredict_pending}, {31'b0, m_pend});
    chk("flush",   {31'b0, flush},              {31'b0, fl});
    chk("redir_v", {31'b0, redirect_valid},     {31'b0, fl});
    chk("redir_pc", redirect_pc,                fl ? m_tgt : 32'h0);
    chk("stall",   {31'b0, frontend_stall},     {31'b0, (m_rec > 0)});
  endtask

  // Drive one cycle of inputs, let the edge happen, then check at the falling edge.
  task automatic step(input logic r, input logic bv, input logic miss, input int id,
                      input logic [31:0] tgt, input int head, input logic cv);
    rst               = r;
    br_valid          = bv;
    br_miss_predict   = miss;
    br_rob_id         = W'(id);
    br_target_address = tgt;
    rob_head_id       = W'(head);
    rob_commit_valid  = cv;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n, input int head);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 32'h0, head, 0);
  endtask

  initial begin
    m_pend = 0; m_id = 0; m_tgt = 0; m_rec = 0;

    // Reset held with a mispredict broadcast present.
    for (int i = 0; i < 3; i++) step(0, 1, 1, 7, 32'hDEAD_BEEF, 0, 1);
    chk("rst_pc", redirect_pc, 32'h0);
    idle(1, 0);
    chk("rst_idle_pend", {31'b0, mispredict_pending}, 32'h0);

    // Basic recovery.
    step(1, 1, 1, 5, 32'h0000_1040, 0, 0);
    chk("basic_pend", {31'b0, mispredict_pending}, 32'h1);
    idle(4, 0);
    step(1, 0, 0, 0, 32'h0, 5, 1);
    chk("basic_flush", {31'b0, flush}, 32'h1);
    chk("basic_pc", redirect_pc, 32'h0000_1040);
    idle(1, 6);
    chk("basic_flush_1cyc", {31'b0, flush}, 32'h0);
    chk("basic_drain_stall", {31'b0, frontend_stall}, 32'h1);
    idle(1, 6);
    chk("basic_drain2_stall", {31'b0, frontend_stall}, 32'h1);
    idle(1, 6);
    chk("basic_end_stall", {31'b0, frontend_stall}, 32'h0);

    // Older replaces younger across the wrap point.
    step(1, 1, 1, 1, 32'h100, 30, 0);
    step(1, 1, 1, 31, 32'h200, 30, 0);
    step(1, 0, 0, 0, 32'h0, 31, 1);
    chk("older_pc", redirect_pc, 32'h200);
    idle(3, 0);
    step(1, 0, 0, 0, 32'h0, 1, 1);
    chk("older_no_reflush", {31'b0, flush}, 32'h0);

    // Younger ignored.
    step(1, 1, 1, 3, 32'h300, 2, 0);
    step(1, 1, 1, 6, 32'h600, 2, 0);
    step(1, 0, 0, 0, 32'h0, 3, 1);
    chk("younger_pc", redirect_pc, 32'h300);
    idle(3, 4);

    // Commit and broadcast in the same cycle: commit wins.
    step(1, 1, 1, 12, 32'hC00, 10, 0);
    step(1, 1, 1, 11, 32'hBAD, 12, 1);
    chk("simul_pc", redirect_pc, 32'hC00);

    // Broadcasts during recovery are dropped.
    step(1, 1, 1, 13, 32'h111, 12, 0);
    step(1, 1, 1, 14, 32'h222, 12, 0);
    idle(1, 12);
    chk("drop_pend", {31'b0, mispredict_pending}, 32'h0);

    // Reset while draining.
    step(1, 1, 1, 4, 32'h444, 0, 0);
    step(1, 0, 0, 0, 32'h0, 4, 1);
    step(1, 0, 0, 0, 32'h0, 5, 0);
    step(0, 0, 0, 0, 32'h0, 5, 0);
    chk("rst_drain_stall", {31'b0, frontend_stall}, 32'h0);
    idle(2, 0);

    // Randomized traffic with small id range so commits frequently match.
    for (int i = 0; i < 4000; i++) begin
      logic r;
      int   head;
      int   id;
      r    = ($urandom_range(0, 99) != 0);
      head = ($urandom_range(0, 1) != 0) ? $urandom_range(28, 35) % DEPTH : $urandom_range(0, DEPTH - 1);
      id   = ($urandom_range(0, 1) != 0) ? (head + $urandom_range(0, 6)) % DEPTH : $urandom_range(0, DEPTH - 1);
      if (m_pend && $urandom_range(0, 3) == 0) head = m_id;
      step(r, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0), id,
           $urandom, head, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
